// File: rtl/pattern_scan_ctrl.sv
// ---------------------------------------------------------------------------
// pattern_scan_ctrl
//
// Stream-level front-end for the bit-serial pattern detector. Words arrive
// over a valid/ready handshake, are serialized MSB-first through a sliding
// match window and every (overlapping) occurrence of the pattern is counted.
// Window, fill level, count and pattern persist across the words of a stream,
// so matches that straddle word boundaries are found. The per-stream hit
// count is returned over a second valid/ready handshake.
//
// Optional feature: define PSC_OVF_EN to add the ovf output, which flags a
// match that arrived while the hit counter was already saturated.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-low reset
//   in_valid   input word valid
//   in_ready   controller can accept a word (registered)
//   in_data    word to scan, MSB shifted first
//   in_last    word is the final word of the stream
//   pat        pattern, MSB = oldest bit; sampled on the first word of a stream
//   ser_bit    bit currently entering the window (registered)
//   ser_valid  ser_bit is meaningful (registered)
//   hit        one-cycle pulse per match, cycle after the completing bit
//   out_valid  stream result valid (registered)
//   out_ready  consumer accepts the result
//   out_count  hits in the stream, saturating (registered)
//   ovf        counter overflowed in this stream (PSC_OVF_EN only)
// ---------------------------------------------------------------------------
module pattern_scan_ctrl #(
    parameter int DATA_W = 16,
    parameter int PAT_W  = 3,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    input  logic [PAT_W-1:0]  pat,
    output logic              ser_bit,
    output logic              ser_valid,
    output logic              hit,
    output logic              out_valid,
    input  logic              out_ready,
`ifdef PSC_OVF_EN
    output logic [CNT_W-1:0]  out_count,
    output logic              ovf
`else
    output logic [CNT_W-1:0]  out_count
`endif
);

    localparam int IDX_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int FILL_W = $clog2(PAT_W + 1);

    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_W - 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
    localparam logic [FILL_W-1:0] FILL_CMP  = FILL_W'(PAT_W - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t              state_r;
    logic                in_ready_r;
    logic [DATA_W-1:0]   word_r;      // remaining bits, next bit at MSB
    logic                last_r;
    logic [PAT_W-1:0]    pat_r;
    logic [IDX_W-1:0]    idx_r;
    logic [PAT_W-1:0]    window_r;
    logic [FILL_W-1:0]   fill_r;
    logic [CNT_W-1:0]    count_r;
    logic                ser_bit_r;
    logic                ser_valid_r;
    logic                hit_r;
    logic                out_valid_r;
    logic [CNT_W-1:0]    out_count_r;
`ifdef PSC_OVF_EN
    logic                ovf_r;
`endif

    logic [PAT_W-1:0]    window_next_s;
    logic [FILL_W-1:0]   fill_next_s;
    logic [CNT_W-1:0]    count_next_s;
    logic                match_s;
    logic                count_sat_s;
    logic                new_stream_s;

    // Saturating increment of the hit counter.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value,
                                                 input logic              en);
        logic [CNT_W-1:0] result;
        if (en && (value != {CNT_W{1'b1}})) begin
            result = value + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            result = value;
        end
        return result;
    endfunction

    // Window update and match detection for the bit currently on ser_bit.
    always_comb begin
        window_next_s = {window_r[PAT_W-2:0], ser_bit_r};
        count_sat_s   = (count_r == {CNT_W{1'b1}});
        new_stream_s  = (fill_r == {FILL_W{1'b0}}) && (count_r == {CNT_W{1'b0}});
        if (fill_r == FILL_FULL) begin
            fill_next_s = fill_r;
        end else begin
            fill_next_s = fill_r + {{(FILL_W-1){1'b0}}, 1'b1};
        end
        // The window is only trusted once PAT_W-1 history bits are present.
        if ((state_r == SHIFT) && (fill_r >= FILL_CMP) && (window_next_s == pat_r)) begin
            match_s = 1'b1;
        end else begin
            match_s = 1'b0;
        end
        count_next_s = sat_inc(count_r, match_s);
    end

    // Controller state machine with registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b0;
            word_r      <= {DATA_W{1'b0}};
            last_r      <= 1'b0;
            pat_r       <= {PAT_W{1'b0}};
            idx_r       <= {IDX_W{1'b0}};
            window_r    <= {PAT_W{1'b0}};
            fill_r      <= {FILL_W{1'b0}};
            count_r     <= {CNT_W{1'b0}};
            ser_bit_r   <= 1'b0;
            ser_valid_r <= 1'b0;
            hit_r       <= 1'b0;
            out_valid_r <= 1'b0;
            out_count_r <= {CNT_W{1'b0}};
`ifdef PSC_OVF_EN
            ovf_r       <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    hit_r      <= 1'b0;
                    in_ready_r <= 1'b1;
                    if (in_valid && in_ready_r) begin
                        // First bit goes straight to ser_bit; the rest wait in word_r.
                        ser_bit_r   <= in_data[DATA_W-1];
                        ser_valid_r <= 1'b1;
                        word_r      <= {in_data[DATA_W-2:0], 1'b0};
                        last_r      <= in_last;
                        idx_r       <= {IDX_W{1'b0}};
                        in_ready_r  <= 1'b0;
                        state_r     <= SHIFT;
                        // Pattern is frozen for the whole stream.
                        if (new_stream_s) begin
                            pat_r <= pat;
                        end
                    end
                end
                SHIFT: begin
                    window_r <= window_next_s;
                    fill_r   <= fill_next_s;
                    count_r  <= count_next_s;
                    hit_r    <= match_s;
`ifdef PSC_OVF_EN
                    if (match_s && count_sat_s) begin
                        ovf_r <= 1'b1;
                    end
`endif
                    if (idx_r == IDX_LAST) begin
                        ser_bit_r   <= 1'b0;
                        ser_valid_r <= 1'b0;
                        if (last_r) begin
                            out_valid_r <= 1'b1;
                            out_count_r <= count_next_s;
                            state_r     <= REPORT;
                        end else begin
                            in_ready_r <= 1'b1;
                            state_r    <= IDLE;
                        end
                    end else begin
                        ser_bit_r <= word_r[DATA_W-1];
                        word_r    <= {word_r[DATA_W-2:0], 1'b0};
                        idx_r     <= idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
                    end
                end
                REPORT: begin
                    hit_r <= 1'b0;
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        out_count_r <= {CNT_W{1'b0}};
                        count_r     <= {CNT_W{1'b0}};
                        window_r    <= {PAT_W{1'b0}};
                        fill_r      <= {FILL_W{1'b0}};
`ifdef PSC_OVF_EN
                        ovf_r       <= 1'b0;
`endif
                        in_ready_r  <= 1'b1;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    in_ready_r  <= 1'b0;
                    ser_valid_r <= 1'b0;
                    hit_r       <= 1'b0;
                    out_valid_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign ser_bit   = ser_bit_r;
    assign ser_valid = ser_valid_r;
    assign hit       = hit_r;
    assign out_valid = out_valid_r;
    assign out_count = out_count_r;
`ifdef PSC_OVF_EN
    assign ovf       = ovf_r;
`endif

endmodule
